// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Owns the PC and drives a synchronous instruction ROM that has a 1-cycle
//   read latency. Returned words are buffered in a 2-entry queue and offered
//   to the instruction register over a valid/ready handshake. The unit
//   handles branch redirects (flush) and stops fetching after a HALT opcode.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   imem_en        ROM read enable
//   imem_addr      ROM address (current pc)
//   imem_rdata     ROM data, valid the cycle after an enabled edge
//   instr_out      head-of-queue instruction
//   pc_out         address of instr_out
//   instr_valid    queue non-empty
//   instr_ready    consumer accepts (pop on valid && ready)
//   branch_valid   one-cycle redirect request
//   branch_target  redirect address
//   halted         high while in the HALTED state
//
// Optional build macro IFU_PERF_CNT_EN adds saturating 32-bit counters:
//   fetch_count    accepted handshakes
//   stall_count    cycles with instr_valid && !instr_ready
//
// State    | meaning
// ---------+-------------------------------------------------------
// S_IDLE   | first cycle out of reset, no fetch, no redirect
// S_RUN    | fetching under the queue credit rule
// S_HALTED | HALT word enqueued, no further fetch until a redirect

module instr_fetch_unit #(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 24,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_inflight;
  logic [1:0]         r_count;
  logic [INSTR_W-1:0] r_q_data [2];
  logic [ADDR_W-1:0]  r_q_pc   [2];

  logic w_pop;
  logic w_flush;
  logic w_push;
  logic w_halt_push;
  logic w_credit;
  logic w_issue;

  assign w_pop       = instr_valid && instr_ready;
  // Redirects are ignored in IDLE; there is nothing in flight yet.
  assign w_flush     = branch_valid && (r_state != S_IDLE);
  // A response that lands on a redirect edge belongs to the old stream.
  assign w_push      = r_inflight && !w_flush;
  assign w_halt_push = w_push && (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
  // Queue entries plus the outstanding read, net of this cycle's pop, must
  // leave room for one more word so a push never hits a full queue.
  assign w_credit    = (({1'b0, r_count} + {2'b00, r_inflight}) - {2'b00, w_pop}) < 3'd2;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_RUN;
      S_RUN: begin
        // The HALT word's own edge cancels any new fetch.
        w_issue = !w_flush && !w_halt_push && w_credit;
        if (w_halt_push) w_state_nxt = S_HALTED;
      end
      S_HALTED: ;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) w_state_nxt = S_RUN;
  end

  assign imem_en     = w_issue;
  assign imem_addr   = r_pc;
  assign instr_valid = (r_count != 2'd0);
  assign instr_out   = r_q_data[0];
  assign pc_out      = r_q_pc[0];
  assign halted      = (r_state == S_HALTED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_flush) begin
        r_pc <= branch_target;
      end else if (w_issue) begin
        r_pc     <= r_pc + PC_ONE;
        r_req_pc <= r_pc;
      end
    end
  end

  // Entry 0 is always the head. A pop that empties the queue leaves entry 0
  // untouched so the outputs hold their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count     <= 2'd0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
    end else if (w_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_q_data[0] <= imem_rdata;
            r_q_pc[0]   <= r_req_pc;
          end else begin
            r_q_data[1] <= imem_rdata;
            r_q_pc[1]   <= r_req_pc;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_q_data[0] <= r_q_data[1];
            r_q_pc[0]   <= r_q_pc[1];
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_data[0] <= imem_rdata;
            r_q_pc[0]   <= r_req_pc;
          end else begin
            r_q_data[0] <= r_q_data[1];
            r_q_pc[0]   <= r_q_pc[1];
            r_q_data[1] <= imem_rdata;
            r_q_pc[1]   <= r_req_pc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (w_pop && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (instr_valid && !instr_ready && (stall_count != 32'hFFFF_FFFF))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. The reference model tracks the expected
// instruction stream (next pc to be delivered, halt and redirect effects)
// and the number of fetched-but-unconsumed words, independent of the
// unit's internal structure. Build with IFU_PERF_CNT_EN to also check the
// performance counters.

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [23:0] imem_rdata = '0;
  logic [23:0] instr_out;
  logic [7:0]  pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_valid = 1'b0;
  logic [7:0]  branch_target = '0;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halted        (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  // Synchronous ROM, 1-cycle latency.
  logic [23:0] rom [256];
  always @(posedge clk) if (imem_en) imem_rdata <= rom[imem_addr];

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  exp_pc;
  bit          halt_seen;
  bit          post_br;
  bit          prev_stall;
  logic [23:0] prev_out;
  int          occ;
  int          n_acc;
  int          n_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_pc     = 8'h00;
    halt_seen  = 1'b0;
    post_br    = 1'b0;
    prev_stall = 1'b0;
    occ        = 0;
    n_acc      = 0;
    n_stall    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset        = 1'b0;
    instr_ready  = 1'b0;
    branch_valid = 1'b0;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_imem_en", imem_en, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One clock: drive inputs at the falling edge, then check the outputs the
  // unit presents for the coming rising edge and advance the model.
  task automatic cycle(input bit rdy, input bit br, input logic [7:0] tgt);
    bit pop;
    @(negedge clk);
    instr_ready   = rdy;
    branch_valid  = br;
    branch_target = tgt;
    #1;
`ifdef IFU_PERF_CNT_EN
    chk("fetch_count", fetch_count, n_acc);
    chk("stall_count", stall_count, n_stall);
`endif
    if (post_br) begin
      chk("redir_valid", instr_valid, 0);
      chk("redir_halted", halted, 0);
    end
    if (prev_stall) begin
      chk("hold_valid", instr_valid, 1);
      chk("hold_data", instr_out, prev_out);
    end
    if (halt_seen) begin
      chk("halt_no_fetch", imem_en, 0);
      chk("halt_no_valid", instr_valid, 0);
    end
    pop = instr_valid && rdy;
    if (pop && !halt_seen) begin
      chk("stream_pc", pc_out, exp_pc);
      chk("stream_word", instr_out, rom[exp_pc]);
      if (rom[exp_pc][23:20] == 4'hF) begin
        chk("halt_flag", halted, 1);
        halt_seen = 1'b1;
      end
      exp_pc = exp_pc + 8'd1;
    end
    if (br) chk("redir_imem_en", imem_en, 0);
    if (instr_valid && rdy) n_acc++;
    if (instr_valid && !rdy) n_stall++;
    occ = br ? 0 : occ + int'(imem_en) - int'(pop);
    chk("occupancy_le2", (occ <= 2), 1);
    prev_stall = instr_valid && !rdy && !br;
    prev_out   = instr_out;
    post_br    = br;
    if (br) begin
      exp_pc    = tgt;
      halt_seen = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      rom[i] = {4'($urandom_range(0, 14)), 20'($urandom)};
    rom[0]     = 24'h120005;
    rom[1]     = 24'h230010;
    rom[2]     = 24'h310001;
    rom[3]     = 24'h040002;
    rom[5]     = 24'hF00000;
    rom[8'h90] = 24'hF12345;
    rom[8'hC3] = 24'hFABCDE;
    model_reset();

    // In-order stream at full rate, first valid after the third edge.
    do_reset();
    cycle(1, 0, 0); chk("lat_s1_valid", instr_valid, 0);
    cycle(1, 0, 0); chk("lat_s2_valid", instr_valid, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0);
      chk("rate_valid", instr_valid, 1);
      chk("rate_pc", pc_out, i);
    end

    // Back-pressure: queue fills and fetching stops.
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0);
      chk("stall_head", instr_out, 24'h120005);
    end
    chk("stall_imem_en", imem_en, 0);
    chk("stall_queue_full", occ, 2);
    // Drain through the HALT word at pc 5.
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    chk("halt_state", halted, 1);
    chk("halt_imem_en", imem_en, 0);
    chk("halt_drained", instr_valid, 0);

    // Redirect out of HALTED.
    cycle(1, 1, 8'h10);
    cycle(1, 0, 0);
    cycle(1, 0, 0); chk("redir_gap", instr_valid, 0);
    cycle(1, 0, 0);
    chk("resume_valid", instr_valid, 1);
    chk("resume_pc", pc_out, 8'h10);
    chk("resume_halted", halted, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    // Redirect with a full queue; stale words must not appear.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    cycle(0, 1, 8'h40);
    cycle(1, 0, 0);
    cycle(1, 0, 0); chk("flush_gap", instr_valid, 0);
    cycle(1, 0, 0);
    chk("flush_valid", instr_valid, 1);
    chk("flush_pc", pc_out, 8'h40);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    // PC wrap.
    cycle(1, 1, 8'hFE);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0); chk("wrap_pc_fe", pc_out, 8'hFE);
    cycle(1, 0, 0); chk("wrap_pc_ff", pc_out, 8'hFF);
    cycle(1, 0, 0); chk("wrap_pc_00", pc_out, 8'h00);
    cycle(1, 0, 0);

    // Reset mid-stream, restart at the reset PC.
    do_reset();
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("restart_valid", instr_valid, 1);
    chk("restart_pc", pc_out, 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit         rdy;
      bit         br;
      logic [7:0] tgt;
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 39) == 0);
      tgt = 8'($urandom);
      cycle(rdy, br, tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
